// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
// Contents: state_t FSM encoding, master index constants, counter width.
package sram_arb_pkg;

    localparam int CNT_W     = 4;
    localparam int N_MASTERS = 3;

    localparam int M_IBUS = 0;
    localparam int M_DBUS = 1;
    localparam int M_DMA  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - bus-master side of the SRAM arbiter
// Signals per master N=0..2: mN_req, mN_we, mN_addr (bank bit at ADDR_W),
// mN_be, mN_wdata, mN_ack; rdata is shared by all masters.
// Modports: slave (arbiter side), master (requester side).
interface sram_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W:0]   m0_addr;
    logic [3:0]        m0_be;
    logic [31:0]       m0_wdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W:0]   m1_addr;
    logic [3:0]        m1_be;
    logic [31:0]       m1_wdata;
    logic              m1_ack;

    logic              m2_req;
    logic              m2_we;
    logic [ADDR_W:0]   m2_addr;
    logic [3:0]        m2_be;
    logic [31:0]       m2_wdata;
    logic              m2_ack;

    logic [31:0]       rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_be, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_be, m1_wdata,
        input  m2_req, m2_we, m2_addr, m2_be, m2_wdata,
        output m0_ack, m1_ack, m2_ack, rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_be, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_be, m1_wdata,
        output m2_req, m2_we, m2_addr, m2_be, m2_wdata,
        input  m0_ack, m1_ack, m2_ack, rdata
    );

endinterface

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational grant picker
// Ports: req (request vector), starved (counter-saturated flags),
// grant (one-hot winner, all zero when nothing requests).
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [N_MASTERS-1:0] req,
    input  logic [N_MASTERS-1:0] starved,
    output logic [N_MASTERS-1:0] grant
);

    logic [N_MASTERS-1:0] cand;

    // Starved requesters form the candidate set when any exist; within the
    // set the fixed order m1 > m0 > m2 breaks ties.
    always_comb begin
        cand  = ((req & starved) != '0) ? (req & starved) : req;
        grant = '0;
        if (cand[M_DBUS]) begin
            grant[M_DBUS] = 1'b1;
        end else if (cand[M_IBUS]) begin
            grant[M_IBUS] = 1'b1;
        end else if (cand[M_DMA]) begin
            grant[M_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-master arbiter for an asynchronous SRAM pair
// Ports: clk, rst (sync, active-high); bus (sram_arbiter_if.slave, master
// requests/acks and shared rdata); ram_addr, base_ce_n, ext_ce_n, ram_oe_n,
// ram_we_n, ram_be_n, ram_dout, ram_dout_en (registered pin drive);
// ram_din (pad read data).
// Build option: SRAM_ARB_DMA_EN lets m2 arbitrate; otherwise m2 is ignored
// and m2_ack is tied low.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int WAIT_RD    = 1,
    parameter int WAIT_WR    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    sram_arbiter_if.slave       bus,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                base_ce_n,
    output logic                ext_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    output logic [3:0]          ram_be_n,
    output logic [31:0]         ram_dout,
    output logic                ram_dout_en,
    input  logic [31:0]         ram_din
);

`ifdef SRAM_ARB_DMA_EN
    localparam int N_ACT = 3;
`else
    localparam int N_ACT = 2;
`endif

    logic [N_MASTERS-1:0] req_vec;
    logic [N_MASTERS-1:0] starved;
    logic [N_MASTERS-1:0] grant;
    logic [CNT_W-1:0]     starve_cnt [N_ACT];

    state_t               state, state_d;
    logic [CNT_W-1:0]     wait_cnt, wait_cnt_d;
    logic                 lat_we, lat_we_d;
    logic [ADDR_W:0]      lat_addr, lat_addr_d;
    logic [3:0]           lat_be, lat_be_d;
    logic [31:0]          lat_wdata, lat_wdata_d;
    logic [1:0]           gnt_idx, gnt_idx_d;

    logic                 win_we;
    logic [ADDR_W:0]      win_addr;
    logic [3:0]           win_be;
    logic [31:0]          win_wdata;
    logic [1:0]           win_idx;

    logic                 base_ce_n_d, ext_ce_n_d, ram_oe_n_d, ram_we_n_d;
    logic [3:0]           ram_be_n_d;
    logic                 ram_dout_en_d;
    logic [N_ACT-1:0]     ack_q, ack_d;
    logic [31:0]          rdata_q;

`ifdef SRAM_ARB_DMA_EN
    assign req_vec    = {bus.m2_req, bus.m1_req, bus.m0_req};
    assign bus.m2_ack = ack_q[M_DMA];
`else
    assign req_vec    = {1'b0, bus.m1_req, bus.m0_req};
    assign bus.m2_ack = 1'b0;
`endif
    assign bus.m0_ack = ack_q[M_IBUS];
    assign bus.m1_ack = ack_q[M_DBUS];
    assign bus.rdata  = rdata_q;
    assign ram_addr   = lat_addr[ADDR_W-1:0];
    assign ram_dout   = lat_wdata;

    always_comb begin
        starved = '0;
        for (int i = 0; i < N_ACT; i++) begin
            starved[i] = (starve_cnt[i] == CNT_W'(STARVE_MAX));
        end
    end

    sram_arb_pick u_pick (
        .req     (req_vec),
        .starved (starved),
        .grant   (grant)
    );

    // Qualifiers of the winning master.
    always_comb begin
        win_we    = bus.m0_we;
        win_addr  = bus.m0_addr;
        win_be    = bus.m0_be;
        win_wdata = bus.m0_wdata;
        win_idx   = 2'(M_IBUS);
        if (grant[M_DBUS]) begin
            win_we    = bus.m1_we;
            win_addr  = bus.m1_addr;
            win_be    = bus.m1_be;
            win_wdata = bus.m1_wdata;
            win_idx   = 2'(M_DBUS);
        end
`ifdef SRAM_ARB_DMA_EN
        else if (grant[M_DMA]) begin
            win_we    = bus.m2_we;
            win_addr  = bus.m2_addr;
            win_be    = bus.m2_be;
            win_wdata = bus.m2_wdata;
            win_idx   = 2'(M_DMA);
        end
`endif
    end

    // State and registered outputs. Outputs are decoded from the next state
    // so every pin changes on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_be      <= '0;
            lat_wdata   <= '0;
            gnt_idx     <= '0;
            base_ce_n   <= 1'b1;
            ext_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_be_n    <= 4'hF;
            ram_dout_en <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_cnt_d;
            lat_we      <= lat_we_d;
            lat_addr    <= lat_addr_d;
            lat_be      <= lat_be_d;
            lat_wdata   <= lat_wdata_d;
            gnt_idx     <= gnt_idx_d;
            base_ce_n   <= base_ce_n_d;
            ext_ce_n    <= ext_ce_n_d;
            ram_oe_n    <= ram_oe_n_d;
            ram_we_n    <= ram_we_n_d;
            ram_be_n    <= ram_be_n_d;
            ram_dout_en <= ram_dout_en_d;
            ack_q       <= ack_d;
            // Pads are sampled at the end of the last oe_n-low cycle.
            if (state == ACCESS && wait_cnt == '0 && !lat_we) begin
                rdata_q <= ram_din;
            end
        end
    end

    always_comb begin
        state_d     = state;
        wait_cnt_d  = wait_cnt;
        lat_we_d    = lat_we;
        lat_addr_d  = lat_addr;
        lat_be_d    = lat_be;
        lat_wdata_d = lat_wdata;
        gnt_idx_d   = gnt_idx;
        case (state)
            IDLE: begin
                if (grant != '0) begin
                    state_d     = ACCESS;
                    lat_we_d    = win_we;
                    lat_addr_d  = win_addr;
                    lat_be_d    = win_be;
                    lat_wdata_d = win_wdata;
                    gnt_idx_d   = win_idx;
                    wait_cnt_d  = win_we ? CNT_W'(WAIT_WR - 1) : CNT_W'(WAIT_RD - 1);
                end
            end
            ACCESS: begin
                if (wait_cnt == '0) begin
                    state_d = RECOVER;
                end else begin
                    wait_cnt_d = wait_cnt - CNT_W'(1);
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_ce_n_d   = 1'b1;
        ext_ce_n_d    = 1'b1;
        ram_oe_n_d    = 1'b1;
        ram_we_n_d    = 1'b1;
        ram_be_n_d    = 4'hF;
        ram_dout_en_d = 1'b0;
        ack_d         = '0;
        if (state_d == ACCESS || state_d == RECOVER) begin
            if (lat_addr_d[ADDR_W]) begin
                ext_ce_n_d = 1'b0;
            end else begin
                base_ce_n_d = 1'b0;
            end
            // Write lanes and pad drive stay on through RECOVER for hold time.
            ram_be_n_d    = lat_we_d ? ~lat_be_d : 4'h0;
            ram_dout_en_d = lat_we_d;
        end
        if (state_d == ACCESS) begin
            ram_oe_n_d = lat_we_d;
            ram_we_n_d = ~lat_we_d;
        end
        if (state_d == RECOVER) begin
            for (int i = 0; i < N_ACT; i++) begin
                ack_d[i] = (gnt_idx_d == 2'(i));
            end
        end
    end

    // A requester that loses in IDLE ages toward promotion; a grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ACT; i++) begin
                starve_cnt[i] <= '0;
            end
        end else if (state == IDLE) begin
            for (int i = 0; i < N_ACT; i++) begin
                if (grant[i]) begin
                    starve_cnt[i] <= '0;
                end else if (req_vec[i] && starve_cnt[i] != CNT_W'(STARVE_MAX)) begin
                    starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule
